// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access-size codes, FSM states,
// the captured request record and the access-size legality check.
package dmem_pkg;

    // RV32I load/store funct3 access-size codes.
    typedef enum logic [2:0] {
        SIZE_B  = 3'b000,
        SIZE_H  = 3'b001,
        SIZE_W  = 3'b010,
        SIZE_BU = 3'b100,
        SIZE_HU = 3'b101
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // The size field stays raw so that illegal codes survive capture and can be flagged.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
    } req_t;

    function automatic logic size_legal(input logic [2:0] size, input logic we);
        logic legal;
        case (size)
            SIZE_B, SIZE_H, SIZE_W: legal = 1'b1;
            SIZE_BU, SIZE_HU:       legal = ~we;
            default:                legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core's memory stage (master) and the responder (slave).
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: byte enables and replicated write lanes for stores,
// byte/half extraction with sign or zero extension for loads.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wlane_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Misaligned halves and words are masked here by ignoring the low offset bits.
    assign byte_sel = rword_i[{offset_i, 3'b000} +: 8];
    assign half_sel = offset_i[1] ? rword_i[31:16] : rword_i[15:0];

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        be_o    = 4'b0000;
        wlane_o = '0;
        rdata_o = '0;
        case (size_i)
            SIZE_B, SIZE_BU: begin
                be_o    = 4'b0001 << offset_i;
                wlane_o = {4{wdata_i[7:0]}};
                rdata_o = (size_i == SIZE_B) ? {{24{byte_sel[7]}}, byte_sel}
                                             : {24'h00_0000, byte_sel};
            end
            SIZE_H, SIZE_HU: begin
                be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
                wlane_o = {2{wdata_i[15:0]}};
                rdata_o = (size_i == SIZE_H) ? {{16{half_sel[15]}}, half_sel}
                                             : {16'h0000, half_sel};
            end
            SIZE_W: begin
                be_o    = 4'b1111;
                wlane_o = wdata_i;
                rdata_o = rword_i;
            end
            default: begin
                be_o    = 4'b0000;
                wlane_o = '0;
                rdata_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder in front of a byte-addressed RAM with
// programmable wait states. Define DMEM_MISALIGN_ERR_EN to fault misaligned H/W accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 131072,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned LATENCY     = 2
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave bus
);

    localparam int unsigned WORDS = DEPTH_BYTES / 4;
    localparam int unsigned IDX_W = $clog2(WORDS);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0]      offset;
    logic [IDX_W-1:0] word_idx;
    logic             range_err;
    logic             size_err;
    logic             align_err;
    logic             access_err;
    logic             commit;
    logic             mem_we;
    logic [3:0]       be;
    logic [31:0]      wlane;
    logic [31:0]      load_data;
    logic [31:0]      mem_rword;

    logic [31:0] mem [WORDS];

    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign offset    = req_q.addr - BASE_ADDR;
    assign word_idx  = offset[IDX_W+1:2];
    assign range_err = (offset >= DEPTH_BYTES);
    assign size_err  = ~size_legal(req_q.size, req_q.we);

`ifdef DMEM_MISALIGN_ERR_EN
    always_comb begin
        align_err = 1'b0;
        case (req_q.size)
            SIZE_H, SIZE_HU: align_err = req_q.addr[0];
            SIZE_W:          align_err = |req_q.addr[1:0];
            default:         align_err = 1'b0;
        endcase
    end
`else
    assign align_err = 1'b0;
`endif

    assign access_err = range_err | size_err | align_err;

    dmem_lane_align u_lane_align (
        .size_i   (req_q.size),
        .offset_i (offset[1:0]),
        .wdata_i  (req_q.wdata),
        .rword_i  (mem_rword),
        .be_o     (be),
        .wlane_o  (wlane),
        .rdata_o  (load_data)
    );

    // Gating with rst keeps a store from committing on the edge reset asserts.
    assign commit    = (state_q == WAIT) && (cnt_q == 4'd0);
    assign mem_we    = commit && req_q.we && !access_err && rst;
    assign mem_rword = mem[word_idx];

    // NOTE: RAM contents have no reset so the array maps onto plain block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    req_d.we    = bus.req_we;
                    req_d.addr  = bus.req_addr;
                    req_d.wdata = bus.req_wdata;
                    req_d.size  = bus.req_size;
                    cnt_d       = 4'(LATENCY - 1);
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = access_err;
                    rsp_rdata_d = (access_err || req_q.we) ? 32'h0 : load_data;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE) && rst;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: reset values, latency, lanes, extension,
// backpressure, faults and reset during an outstanding store.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH_BYTES (131072),
        .BASE_ADDR   (32'h0001_0000),
        .LATENCY     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete request/response; hold keeps rsp_ready low for that many cycles.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] size,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int lat;
        bit got;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_size  = size;
        lat = 0;
        while (!bus.req_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            #1 got = bus.rsp_valid;
        end
        check({tag, " latency"}, 32'(lat), 32'd2);
        check({tag, " rdata"}, bus.rsp_rdata, exp_rdata);
        check({tag, " err"}, 32'(bus.rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " stall valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, " stall rdata"}, bus.rsp_rdata, exp_rdata);
            check({tag, " stall req_ready"}, 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        check({tag, " valid drop"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " ready back"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        bit saw_rsp;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_size  = 3'b000;
        bus.rsp_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst req_ready", 32'(bus.req_ready), 32'd0);
        check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst rsp_rdata", bus.rsp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post-rst req_ready", 32'(bus.req_ready), 32'd1);
        check("post-rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("post-rst rsp_err", 32'(bus.rsp_err), 32'd0);

        // Stores and word round trip, including the last in-range word
        xact("sw top", 1'b1, 32'h0002_FFFC, 32'h0BAD_C0DE, SIZE_W, 32'h0, 1'b0, 0);
        xact("sw 20", 1'b1, 32'h0001_0020, 32'hCAFE_F00D, SIZE_W, 32'h0, 1'b0, 0);
        xact("sw 10", 1'b1, 32'h0001_0010, 32'hDEAD_BEEF, SIZE_W, 32'h0, 1'b0, 0);
        xact("lw 10", 1'b0, 32'h0001_0010, 32'h0, SIZE_W, 32'hDEAD_BEEF, 1'b0, 0);

        // Sub-word loads with extension; LHU also exercises backpressure
        xact("lb 10", 1'b0, 32'h0001_0010, 32'h0, SIZE_B, 32'hFFFF_FFEF, 1'b0, 0);
        xact("lbu 10", 1'b0, 32'h0001_0010, 32'h0, SIZE_BU, 32'h0000_00EF, 1'b0, 0);
        xact("lh 12", 1'b0, 32'h0001_0012, 32'h0, SIZE_H, 32'hFFFF_DEAD, 1'b0, 0);
        xact("lhu 12", 1'b0, 32'h0001_0012, 32'h0, SIZE_HU, 32'h0000_DEAD, 1'b0, 5);
        xact("lb 13", 1'b0, 32'h0001_0013, 32'h0, SIZE_B, 32'hFFFF_FFDE, 1'b0, 0);

        // Faults: below base must not alias onto the top word
        xact("sw below", 1'b1, 32'h0000_FFFC, 32'h1111_1111, SIZE_W, 32'h0, 1'b1, 0);
        xact("lw top", 1'b0, 32'h0002_FFFC, 32'h0, SIZE_W, 32'h0BAD_C0DE, 1'b0, 0);
        xact("lw past end", 1'b0, 32'h0003_0000, 32'h0, SIZE_W, 32'h0, 1'b1, 0);
        xact("ld size 011", 1'b0, 32'h0001_0010, 32'h0, 3'b011, 32'h0, 1'b1, 0);
        xact("st size BU", 1'b1, 32'h0001_0010, 32'h0000_00FF, SIZE_BU, 32'h0, 1'b1, 0);
        xact("lw unchanged", 1'b0, 32'h0001_0010, 32'h0, SIZE_W, 32'hDEAD_BEEF, 1'b0, 0);

        // Alignment handling
`ifdef DMEM_MISALIGN_ERR_EN
        xact("sh misalign", 1'b1, 32'h0001_0011, 32'h0000_A55A, SIZE_H, 32'h0, 1'b1, 0);
        xact("sb 13", 1'b1, 32'h0001_0013, 32'h0000_017F, SIZE_B, 32'h0, 1'b0, 0);
        xact("lw merged", 1'b0, 32'h0001_0010, 32'h0, SIZE_W, 32'h7FAD_BEEF, 1'b0, 0);
        xact("lh 12 pos", 1'b0, 32'h0001_0012, 32'h0, SIZE_H, 32'h0000_7FAD, 1'b0, 0);
        xact("lw misalign", 1'b0, 32'h0001_0011, 32'h0, SIZE_W, 32'h0, 1'b1, 0);
`else
        xact("sh misalign", 1'b1, 32'h0001_0011, 32'h0000_A55A, SIZE_H, 32'h0, 1'b0, 0);
        xact("sb 13", 1'b1, 32'h0001_0013, 32'h0000_017F, SIZE_B, 32'h0, 1'b0, 0);
        xact("lw merged", 1'b0, 32'h0001_0010, 32'h0, SIZE_W, 32'h7FAD_A55A, 1'b0, 0);
        xact("lh 12 pos", 1'b0, 32'h0001_0012, 32'h0, SIZE_H, 32'h0000_7FAD, 1'b0, 0);
        xact("lw misalign", 1'b0, 32'h0001_0011, 32'h0, SIZE_W, 32'h7FAD_A55A, 1'b0, 0);
`endif

        // Reset while a store is waiting
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h0001_0020;
        bus.req_wdata = 32'h1234_5678;
        bus.req_size  = SIZE_W;
        check("midrst accept ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst req_ready", 32'(bus.req_ready), 32'd0);
        check("midrst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        saw_rsp = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1 if (bus.rsp_valid) saw_rsp = 1'b1;
        end
        check("midrst no response", 32'(saw_rsp), 32'd0);
        check("midrst ready", 32'(bus.req_ready), 32'd1);
        xact("lw after rst", 1'b0, 32'h0001_0020, 32'h0, SIZE_W, 32'hCAFE_F00D, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
